// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider.
// One trial subtraction per clock. Operands are captured on an accepted start.
// Divide-by-zero is flagged without iterating. All outputs are registered.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] r_shifted;
    logic [WIDTH:0]   trial;

    // Trial subtraction on the left-shifted partial remainder.
    // The partial remainder never exceeds the dividend prefix consumed so far,
    // so the shifted value always fits in WIDTH bits.
    always_comb begin
        r_shifted = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
        trial     = {1'b0, r_shifted} - {1'b0, d_q};
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        count_d = count_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            // DONE accepts a new request just like IDLE, enabling back-to-back use.
            S_IDLE, S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (start) begin
                    if (divisor != '0) begin
                        state_d = S_RUN;
                        r_d     = '0;
                        q_d     = dividend;
                        d_d     = divisor;
                        count_d = CW'(WIDTH);
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end

            S_RUN: begin
                // No borrow: keep the difference and shift in a 1; else restore.
                r_d     = trial[WIDTH] ? r_shifted : trial[WIDTH-1:0];
                q_d     = {q_q[WIDTH-2:0], ~trial[WIDTH]};
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quot_d  = q_d;
                    rem_d   = r_d;
                    dbz_d   = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            count_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            count_q <= count_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Testbench for seq_restoring_divider: directed vector table, hand-written
// multi-cycle sequences and randomized operands for WIDTH = 4, 8 and 16.
module tb_seq_restoring_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH = 8 instance
    logic       st8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, z8;
    logic [7:0] q8, r8;
    // WIDTH = 4 instance
    logic       st4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, z4;
    logic [3:0] q4, r4;
    // WIDTH = 16 instance
    logic        st16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, z16;
    logic [15:0] q16, r16;

    seq_restoring_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .dividend(a8), .divisor(b8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(z8));
    seq_restoring_divider #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .dividend(a4), .divisor(b4),
        .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_by_zero(z4));
    seq_restoring_divider #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .dividend(a16), .divisor(b16),
        .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_by_zero(z16));

    int n_cmp = 0;
    int n_fail = 0;
    int cur_w = 8;

    logic        done_s, busy_s, z_s;
    logic [15:0] q_s, r_s;

    // Route the currently exercised instance onto common observation signals.
    always_comb begin
        done_s = done8; busy_s = busy8; z_s = z8;
        q_s = {8'h00, q8}; r_s = {8'h00, r8};
        if (cur_w == 4) begin
            done_s = done4; busy_s = busy4; z_s = z4;
            q_s = {12'h000, q4}; r_s = {12'h000, r4};
        end else if (cur_w == 16) begin
            done_s = done16; busy_s = busy16; z_s = z16;
            q_s = q16; r_s = r16;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic [15:0] a, input logic [15:0] b);
        cur_w = w;
        case (w)
            4:       begin st4 = s;  a4 = a[3:0];  b4 = b[3:0];  end
            16:      begin st16 = s; a16 = a;      b16 = b;      end
            default: begin st8 = s;  a8 = a[7:0];  b8 = b[7:0];  end
        endcase
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    task automatic ref_div(input int w, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] q, output logic [15:0] r, output logic z);
        logic [15:0] mask;
        mask = 16'((32'd1 << w) - 1);
        if (b == 0) begin
            q = mask; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endtask

    // Issue one request (called at a negedge) and wait, bounded, for done.
    // edges counts posedges from the accepting edge up to the one raising done.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] qo, output logic [15:0] ro, output logic zo,
                          output int edges, output int bcyc);
        drive(w, 1'b1, a, b);
        @(posedge clk);
        edges = 1;
        bcyc = 0;
        @(negedge clk);
        drive(w, 1'b0, ~a, ~b);
        while (!done_s && edges < 60) begin
            if (busy_s) bcyc++;
            @(negedge clk);
            edges++;
        end
        qo = q_s; ro = r_s; zo = z_s;
    endtask

    task automatic check_op(input int w, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] q, r, eq, er;
        logic z, ez;
        int edges, bcyc;
        string tag;
        run_op(w, a, b, q, r, z, edges, bcyc);
        ref_div(w, a, b, eq, er, ez);
        tag = $sformatf("w%0d %0d/%0d", w, a, b);
        $display("op %s -> q=%0d r=%0d dbz=%0d edges=%0d busy=%0d", tag, q, r, z, edges, bcyc);
        chk({tag, " quotient"},    32'(q), 32'(eq));
        chk({tag, " remainder"},   32'(r), 32'(er));
        chk({tag, " div_by_zero"}, 32'(z), 32'(ez));
        chk({tag, " latency"},     32'(edges), ez ? 32'd1 : 32'(w + 1));
        chk({tag, " busy_cycles"}, 32'(bcyc), ez ? 32'd0 : 32'(w));
    endtask

    typedef struct {
        logic [7:0] a, b, q, r;
        logic       z;
    } vec_t;

    vec_t vecs[8];
    int   edges;

    initial begin
        vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
        vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        vecs[4] = '{8'd100, 8'd0,   8'd255, 8'd100, 1'b1};
        vecs[5] = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0};
        vecs[6] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1};
        vecs[7] = '{8'd128, 8'd200, 8'd0,   8'd128, 1'b0};

        // Reset state, observed while rst_n is still low
        #12;
        chk("reset busy", 32'(busy8), 32'd0);
        chk("reset done", 32'(done8), 32'd0);
        chk("reset quotient", 32'(q8), 32'd0);
        chk("reset remainder", 32'(r8), 32'd0);
        chk("reset dbz", 32'(z8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table; also confirm done lasts one cycle and results hold
        foreach (vecs[i]) begin
            logic [15:0] q, r;
            logic z;
            int bcyc;
            run_op(8, 16'(vecs[i].a), 16'(vecs[i].b), q, r, z, edges, bcyc);
            $display("vec %0d: %0d/%0d -> q=%0d r=%0d dbz=%0d edges=%0d", i,
                     vecs[i].a, vecs[i].b, q, r, z, edges);
            chk($sformatf("vec%0d quotient", i), 32'(q), 32'(vecs[i].q));
            chk($sformatf("vec%0d remainder", i), 32'(r), 32'(vecs[i].r));
            chk($sformatf("vec%0d dbz", i), 32'(z), 32'(vecs[i].z));
            chk($sformatf("vec%0d latency", i), 32'(edges), vecs[i].z ? 32'd1 : 32'd9);
            chk($sformatf("vec%0d busy_cycles", i), 32'(bcyc), vecs[i].z ? 32'd0 : 32'd8);
            @(negedge clk);
            chk($sformatf("vec%0d done_pulse", i), 32'(done8), 32'd0);
            chk($sformatf("vec%0d hold quotient", i), 32'(q8), 32'(vecs[i].q));
        end

        // 77/5 with a second request at cycle 3 that must be ignored,
        // then a back-to-back request issued during the done cycle.
        drive(8, 1'b1, 16'd77, 16'd5);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        drive(8, 1'b0, 16'd77, 16'd5);
        @(negedge clk); edges++;
        @(negedge clk); edges++;
        drive(8, 1'b1, 16'd10, 16'd2);
        @(negedge clk); edges++;
        drive(8, 1'b0, 16'd0, 16'd0);
        chk("77/5 busy mid-op", 32'(busy8), 32'd1);
        chk("77/5 quotient held", 32'(q8), 32'd128 - 32'd128 + 32'(vecs[7].q));
        while (!done8 && edges < 60) begin
            @(negedge clk); edges++;
        end
        $display("seq 77/5 (10/2 ignored) -> q=%0d r=%0d edges=%0d", q8, r8, edges);
        chk("77/5 quotient", 32'(q8), 32'd15);
        chk("77/5 remainder", 32'(r8), 32'd2);
        chk("77/5 latency", 32'(edges), 32'd9);
        drive(8, 1'b1, 16'd10, 16'd2);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        drive(8, 1'b0, 16'd0, 16'd0);
        while (!done8 && edges < 60) begin
            @(negedge clk); edges++;
        end
        $display("seq back-to-back 10/2 -> q=%0d r=%0d edges=%0d", q8, r8, edges);
        chk("b2b quotient", 32'(q8), 32'd5);
        chk("b2b remainder", 32'(r8), 32'd0);
        chk("b2b latency", 32'(edges), 32'd9);
        @(negedge clk);

        // Asynchronous reset in the middle of an operation
        drive(8, 1'b1, 16'd200, 16'd7);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b0, 16'd0, 16'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        $display("seq reset mid-op -> busy=%0d q=%0d r=%0d", busy8, q8, r8);
        chk("abort busy", 32'(busy8), 32'd0);
        chk("abort done", 32'(done8), 32'd0);
        chk("abort quotient", 32'(q8), 32'd0);
        chk("abort remainder", 32'(r8), 32'd0);
        chk("abort dbz", 32'(z8), 32'd0);
        begin
            int saw_done = 0;
            repeat (12) begin
                @(negedge clk);
                if (done8) saw_done++;
            end
            rst_n = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (done8) saw_done++;
            end
            chk("abort no done pulse", 32'(saw_done), 32'd0);
        end
        check_op(8, 16'd50, 16'd6);

        // Randomized sweeps against the reference model
        repeat (1500) check_op(8, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                check_op(4, 16'(a), 16'(b));
        repeat (300) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            check_op(16, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
